// File: rtl/morse_decoder_pkg.sv
// rtl/morse_decoder_pkg.sv - shared types and constants for the Morse decoder
// Holds the FSM state enumeration, the A..H letter encodings, the per-letter
// (length, pattern) codes and the default inter-letter gap length.
package morse_decoder_pkg;

  localparam int GAP_UNITS_DEFAULT = 3;

  // Mark and symbol counters only need to reach 4; the gap counter is wider
  // so GAP_UNITS can be raised without touching the datapath.
  localparam int CNT_W = 3;
  localparam int GAP_W = 4;

  localparam logic [CNT_W-1:0] MARK_DOT  = 3'd1;
  localparam logic [CNT_W-1:0] MARK_DASH = 3'd3;
  localparam logic [CNT_W-1:0] MARK_SAT  = 3'd4;
  localparam logic [CNT_W-1:0] SYM_MAX   = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MARK  = 2'd1,
    ST_SPACE = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  localparam logic [2:0] LTR_A = 3'd0;
  localparam logic [2:0] LTR_B = 3'd1;
  localparam logic [2:0] LTR_C = 3'd2;
  localparam logic [2:0] LTR_D = 3'd3;
  localparam logic [2:0] LTR_E = 3'd4;
  localparam logic [2:0] LTR_F = 3'd5;
  localparam logic [2:0] LTR_G = 3'd6;
  localparam logic [2:0] LTR_H = 3'd7;

  // Pattern is right-aligned: first symbol sits at bit (len-1), dot=0, dash=1.
  typedef struct packed {
    logic [2:0] len;
    logic [3:0] pat;
  } code_t;

  localparam code_t CODE_A = '{len: 3'd2, pat: 4'b0001};
  localparam code_t CODE_B = '{len: 3'd4, pat: 4'b1000};
  localparam code_t CODE_C = '{len: 3'd4, pat: 4'b1010};
  localparam code_t CODE_D = '{len: 3'd3, pat: 4'b0100};
  localparam code_t CODE_E = '{len: 3'd1, pat: 4'b0000};
  localparam code_t CODE_F = '{len: 3'd4, pat: 4'b0010};
  localparam code_t CODE_G = '{len: 3'd3, pat: 4'b0110};
  localparam code_t CODE_H = '{len: 3'd4, pat: 4'b0000};

endpackage

// File: rtl/morse_lookup.sv
// rtl/morse_lookup.sv - combinational (length, pattern) to letter lookup
// Ports: length_i  symbol count of the finished letter (1..4)
//        pattern_i right-aligned dot/dash pattern
//        letter_o  A..H encoding, 0 when there is no match
//        match_o   1 when (length_i, pattern_i) is a known letter
module morse_lookup
  import morse_decoder_pkg::*;
(
  input  logic [2:0] length_i,
  input  logic [3:0] pattern_i,
  output logic [2:0] letter_o,
  output logic       match_o
);

  always_comb begin
    letter_o = 3'd0;
    match_o  = 1'b1;
    case ({length_i, pattern_i})
      CODE_A:  letter_o = LTR_A;
      CODE_B:  letter_o = LTR_B;
      CODE_C:  letter_o = LTR_C;
      CODE_D:  letter_o = LTR_D;
      CODE_E:  letter_o = LTR_E;
      CODE_F:  letter_o = LTR_F;
      CODE_G:  letter_o = LTR_G;
      CODE_H:  letter_o = LTR_H;
      default: match_o  = 1'b0;
    endcase
  end

endmodule

// File: rtl/morse_decoder.sv
// rtl/morse_decoder.sv - strobed serial Morse decoder for letters A..H
// Ports: ClockIn      system clock, rising edge
//        Resetn       asynchronous active-low reset
//        DotDashIn    Morse level (1 = mark), valid only when NewBitIn=1
//        NewBitIn     one-cycle sample strobe
//        Letter       last successfully decoded letter (A=000 .. H=111)
//        LetterValid  one-cycle pulse on a new Letter
//        Error        one-cycle pulse on a malformed or unknown letter
// GAP_UNITS must be at least 2: a single low slot separates symbols.
module morse_decoder
  import morse_decoder_pkg::*;
#(
  parameter int GAP_UNITS = GAP_UNITS_DEFAULT
) (
  input  logic       ClockIn,
  input  logic       Resetn,
  input  logic       DotDashIn,
  input  logic       NewBitIn,
  output logic [2:0] Letter,
  output logic       LetterValid,
  output logic       Error
);

  localparam logic [GAP_W-1:0] GAP_LIM = GAP_W'(GAP_UNITS);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] mark_cnt_q, mark_cnt_d;
  logic [CNT_W-1:0] sym_cnt_q, sym_cnt_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [3:0]       pattern_q, pattern_d;
  logic [2:0]       letter_q, letter_d;
  logic             valid_q, valid_d;
  logic             error_q, error_d;

  logic [GAP_W-1:0] gap_inc;
  logic             decode_evt;
  logic             error_evt;
  logic [2:0]       lk_letter;
  logic             lk_match;

  // Lookup always sees the registered symbol state; it is only consulted on
  // the gap-terminating sample, by which point the last symbol is shifted in.
  morse_lookup u_lookup (
    .length_i  (sym_cnt_q),
    .pattern_i (pattern_q),
    .letter_o  (lk_letter),
    .match_o   (lk_match)
  );

  assign gap_inc = (gap_cnt_q == '1) ? gap_cnt_q : gap_cnt_q + 1'b1;

  always_ff @(posedge ClockIn or negedge Resetn) begin
    if (!Resetn) begin
      state_q    <= ST_IDLE;
      mark_cnt_q <= '0;
      sym_cnt_q  <= '0;
      gap_cnt_q  <= '0;
      pattern_q  <= '0;
      letter_q   <= '0;
      valid_q    <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      mark_cnt_q <= mark_cnt_d;
      sym_cnt_q  <= sym_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      pattern_q  <= pattern_d;
      letter_q   <= letter_d;
      valid_q    <= valid_d;
      error_q    <= error_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    mark_cnt_d = mark_cnt_q;
    sym_cnt_d  = sym_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    pattern_d  = pattern_q;
    decode_evt = 1'b0;
    error_evt  = 1'b0;

    if (NewBitIn) begin
      case (state_q)
        ST_IDLE: begin
          if (DotDashIn) begin
            state_d    = ST_MARK;
            mark_cnt_d = 3'd1;
            sym_cnt_d  = '0;
            gap_cnt_d  = '0;
            pattern_d  = '0;
          end
        end

        ST_MARK: begin
          if (DotDashIn) begin
            if (mark_cnt_q != MARK_SAT) mark_cnt_d = mark_cnt_q + 1'b1;
          end else begin
            // The low sample that ends a mark is also the first gap slot,
            // both for a normal symbol gap and for the drain window.
            mark_cnt_d = '0;
            gap_cnt_d  = 4'd1;
            if ((mark_cnt_q == MARK_DOT || mark_cnt_q == MARK_DASH) &&
                sym_cnt_q != SYM_MAX) begin
              state_d   = ST_SPACE;
              sym_cnt_d = sym_cnt_q + 1'b1;
              pattern_d = {pattern_q[2:0], (mark_cnt_q == MARK_DASH)};
            end else begin
              state_d   = ST_DRAIN;
              error_evt = 1'b1;
            end
          end
        end

        ST_SPACE: begin
          if (DotDashIn) begin
            gap_cnt_d = '0;
            if (gap_cnt_q == 4'd1) begin
              state_d    = ST_MARK;
              mark_cnt_d = 3'd1;
            end else begin
              state_d   = ST_DRAIN;
              error_evt = 1'b1;
            end
          end else if (gap_inc >= GAP_LIM) begin
            state_d    = ST_IDLE;
            decode_evt = 1'b1;
            gap_cnt_d  = '0;
            sym_cnt_d  = '0;
            pattern_d  = '0;
          end else begin
            gap_cnt_d = gap_inc;
          end
        end

        ST_DRAIN: begin
          if (DotDashIn) begin
            gap_cnt_d = '0;
          end else if (gap_inc >= GAP_LIM) begin
            state_d    = ST_IDLE;
            gap_cnt_d  = '0;
            sym_cnt_d  = '0;
            pattern_d  = '0;
            mark_cnt_d = '0;
          end else begin
            gap_cnt_d = gap_inc;
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end
  end

  // decode_evt and error_evt are mutually exclusive, so the pulses never
  // coincide; an unknown pattern turns a decode into an error.
  always_comb begin
    letter_d = letter_q;
    valid_d  = 1'b0;
    error_d  = error_evt;
    if (decode_evt) begin
      if (lk_match) begin
        letter_d = lk_letter;
        valid_d  = 1'b1;
      end else begin
        error_d = 1'b1;
      end
    end
  end

  assign Letter      = letter_q;
  assign LetterValid = valid_q;
  assign Error       = error_q;

endmodule

// File: tb/tb_morse_decoder.sv
// tb/tb_morse_decoder.sv - self-checking bench for morse_decoder
module tb_morse_decoder;

  localparam int GAP = 3;

  logic       ClockIn   = 1'b0;
  logic       Resetn    = 1'b0;
  logic       DotDashIn = 1'b0;
  logic       NewBitIn  = 1'b0;
  logic [2:0] Letter;
  logic       LetterValid;
  logic       Error;

  int n_cmp   = 0;
  int n_fail  = 0;
  int n_valid = 0;
  int n_err   = 0;

  // Reference model state: samples of the letter in progress, drain window.
  bit         cur[$];
  bit         draining    = 1'b0;
  int         drain_zeros = 0;
  logic [2:0] exp_letter  = 3'd0;

  string code_tab[8] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "...."};

  always #5 ClockIn = ~ClockIn;

  morse_decoder #(.GAP_UNITS(GAP)) dut (
    .ClockIn     (ClockIn),
    .Resetn      (Resetn),
    .DotDashIn   (DotDashIn),
    .NewBitIn    (NewBitIn),
    .Letter      (Letter),
    .LetterValid (LetterValid),
    .Error       (Error)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Split the letter-in-progress into runs and judge it as text:
  // 0 = undecided, 1 = malformed, 2 = decoded (idx valid), 3 = unknown code.
  function automatic int analyze(output logic [2:0] idx);
    string sym;
    int    i, n, len, r;
    bit    v;
    sym = "";
    i   = 0;
    n   = cur.size();
    r   = 0;
    idx = 3'd0;
    while (i < n && r == 0) begin
      v   = cur[i];
      len = 0;
      while (i < n && cur[i] == v) begin
        len++;
        i++;
      end
      if (v) begin
        if (i < n) begin
          if (len == 1) sym = {sym, "."};
          else if (len == 3) sym = {sym, "-"};
          else r = 1;
          if (r == 0 && sym.len() > 4) r = 1;
        end
      end else if (i < n) begin
        if (len != 1) r = 1;
      end else if (len >= GAP) begin
        r = 3;
        for (int k = 0; k < 8; k++) begin
          if (r == 3 && code_tab[k] == sym) begin
            idx = 3'(k);
            r   = 2;
          end
        end
      end
    end
    return r;
  endfunction

  task automatic model_step(input bit b, output bit ev_v, output bit ev_e);
    int         kind;
    logic [2:0] idx;
    ev_v = 1'b0;
    ev_e = 1'b0;
    if (draining) begin
      if (b) drain_zeros = 0;
      else drain_zeros++;
      if (drain_zeros >= GAP) draining = 1'b0;
    end else if (cur.size() != 0 || b) begin
      cur.push_back(b);
      kind = analyze(idx);
      if (kind == 1) begin
        ev_e = 1'b1;
        cur.delete();
        draining    = 1'b1;
        drain_zeros = b ? 0 : 1;
      end else if (kind == 2) begin
        ev_v       = 1'b1;
        exp_letter = idx;
        cur.delete();
      end else if (kind == 3) begin
        ev_e = 1'b1;
        cur.delete();
      end
    end
  endtask

  task automatic send_bit(input bit b, input int idle);
    bit ev_v, ev_e;
    NewBitIn  = 1'b1;
    DotDashIn = b;
    @(posedge ClockIn);
    #1;
    model_step(b, ev_v, ev_e);
    if (LetterValid === 1'b1) n_valid++;
    if (Error === 1'b1) n_err++;
    chk("valid", 8'(LetterValid), 8'(ev_v));
    chk("error", 8'(Error), 8'(ev_e));
    chk("letter", 8'(Letter), 8'(exp_letter));
    NewBitIn  = 1'b0;
    DotDashIn = 1'($urandom);
    repeat (idle) begin
      @(posedge ClockIn);
      #1;
      DotDashIn = 1'($urandom);
      chk("quiet", 8'({LetterValid, Error}), 8'd0);
    end
  endtask

  task automatic send_str(input string s, input int idle);
    for (int i = 0; i < s.len(); i++) send_bit(s[i] == 8'h31, idle);
  endtask

  task automatic clr_counts();
    n_valid = 0;
    n_err   = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    string c;
    int    li, ml, gl, extra, nsym;

    repeat (3) @(posedge ClockIn);
    #1;
    chk("rst_letter", 8'(Letter), 8'd0);
    chk("rst_valid", 8'(LetterValid), 8'd0);
    chk("rst_error", 8'(Error), 8'd0);
    Resetn = 1'b1;
    @(posedge ClockIn);
    #1;

    clr_counts();
    send_str("10111000", 3);
    chk("A_letter", 8'(Letter), 8'h0);
    chk("A_nvalid", 8'(n_valid), 8'd1);
    chk("A_nerr", 8'(n_err), 8'd0);

    clr_counts();
    send_str("100000000000", 1);
    chk("E_letter", 8'(Letter), 8'h4);
    chk("E_nvalid", 8'(n_valid), 8'd1);

    clr_counts();
    send_str("11101011101000", 2);
    chk("C_letter", 8'(Letter), 8'h2);
    chk("C_nvalid", 8'(n_valid), 8'd1);

    clr_counts();
    send_str("11110", 1);
    chk("long_mark_nerr", 8'(n_err), 8'd1);
    chk("long_mark_nvalid", 8'(n_valid), 8'd0);
    clr_counts();
    send_str("0001010101000", 1);
    chk("H_letter", 8'(Letter), 8'h7);
    chk("H_nvalid", 8'(n_valid), 8'd1);

    send_str("11101", 1);
    Resetn = 1'b0;
    #1;
    chk("rst_async_letter", 8'(Letter), 8'd0);
    @(posedge ClockIn);
    #1;
    chk("rst_mid_valid", 8'(LetterValid), 8'd0);
    chk("rst_mid_error", 8'(Error), 8'd0);
    @(posedge ClockIn);
    #1;
    Resetn = 1'b1;
    cur.delete();
    draining   = 1'b0;
    exp_letter = 3'd0;
    clr_counts();
    send_str("1110101000", 1);
    chk("D_letter", 8'(Letter), 8'h3);
    chk("D_nvalid", 8'(n_valid), 8'd1);

    clr_counts();
    send_str("101010101000", 1);
    chk("five_dots_nerr", 8'(n_err), 8'd1);
    chk("five_dots_nvalid", 8'(n_valid), 8'd0);
    chk("five_dots_letter", 8'(Letter), 8'h3);

    for (int k = 0; k < 40; k++) begin
      li    = $urandom_range(0, 7);
      c     = code_tab[li];
      extra = ($urandom_range(0, 7) == 0) ? 1 : 0;
      nsym  = c.len() + extra;
      for (int s = 0; s < nsym; s++) begin
        ml = (s >= c.len() || c[s] == 8'h2e) ? 1 : 3;
        if ($urandom_range(0, 9) == 0) ml = $urandom_range(2, 5);
        repeat (ml) send_bit(1'b1, $urandom_range(0, 2));
        gl = ($urandom_range(0, 11) == 0) ? 2 : 1;
        if (s != nsym - 1) repeat (gl) send_bit(1'b0, $urandom_range(0, 2));
      end
      repeat (GAP + $urandom_range(0, 3)) send_bit(1'b0, $urandom_range(0, 2));
    end

    repeat (80) send_bit(1'($urandom_range(0, 1)), $urandom_range(0, 2));
    repeat (GAP + 2) send_bit(1'b0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/morse_decoder.md
MORSE_DECODER -- requirements
Module: morse_decoder

Interface
REQ-001 Parameter GAP_UNITS, default 3: number of consecutive low bit-slots that terminates a letter.
REQ-002 ClockIn  input  1  system clock; all state updates on its rising edge.
REQ-003 Resetn  input  1  reset, asynchronous, active-low.
REQ-004 DotDashIn  input  1  serial Morse level (1 = mark, 0 = space).
REQ-005 NewBitIn  input  1  one-cycle strobe; DotDashIn is valid only in cycles where NewBitIn=1.
REQ-006 Letter  output  3  decoded letter, A=000 to H=111; held until the next successful decode.
REQ-007 LetterValid  output  1  one-cycle pulse marking a new Letter value.
REQ-008 Error  output  1  one-cycle pulse marking a malformed or unrecognised letter.

Function
REQ-009 The block SHALL ignore DotDashIn in every cycle where NewBitIn=0; state changes only on strobed samples.
REQ-010 The FSM SHALL have the states IDLE, MARK, SPACE and DRAIN.
REQ-011 IDLE: sample 0 -> stay; sample 1 -> MARK with mark count=1, symbol count=0 and pattern=0.
REQ-012 MARK: sample 1 -> mark count+1, saturating at 4; sample 0 -> classify the mark and go to SPACE with gap count=1.
REQ-013 Mark classification: count 1 -> dot (shift in 0); count 3 -> dash (shift in 1); count 2 or >=4 -> Error pulse, then DRAIN.
REQ-014 Symbols SHALL shift into a 4-bit pattern with the first symbol as MSB of the used length; a 5th symbol -> Error, then DRAIN.
REQ-015 SPACE: sample 0 -> gap count+1; sample 1 with gap count=1 -> MARK with mark count=1; sample 1 with gap count between 2 and GAP_UNITS-1 -> Error, then DRAIN.
REQ-016 When gap count reaches GAP_UNITS, the block SHALL look up (length, pattern), update Letter and pulse LetterValid, or pulse Error if there is no match, then go to IDLE.
REQ-017 Code table (length:pattern, dot=0, dash=1):
  - A 2:01
  - B 4:1000
  - C 4:1010
  - D 3:100
  - E 1:0
  - F 4:0010
  - G 3:110
  - H 4:0000
REQ-018 LetterValid and Error SHALL be registered and assert in the cycle after the terminating strobe sample; they are never both high.
REQ-019 DRAIN: a sample of 1 restarts the gap count at 0; GAP_UNITS consecutive 0 samples -> IDLE without a pulse.
REQ-020 Trailing zeros beyond GAP_UNITS SHALL be absorbed in IDLE without side effects.
REQ-021 Counters SHALL be at least 3 bits wide and saturate; no wrap-around.

Reset
REQ-022 Resetn=0 SHALL immediately force state=IDLE, all counters and the pattern to 0, Letter=000, LetterValid=0 and Error=0.
REQ-023 Reset asserted mid-letter SHALL discard the partial letter; decoding after release starts fresh at IDLE.

Structure
REQ-024 The shared package SHALL hold the state enumeration, the letter encodings A..H, the per-letter (length, pattern) constants and the default GAP_UNITS.
REQ-025 One sub-module, morse_lookup, SHALL be purely combinational: (length[2:0], pattern[3:0]) -> letter[2:0] plus a match flag.

Verification
REQ-026 Stream 1,0,1,1,1,0,0,0 (A), one strobe every 4 clocks -> Letter=000, a single LetterValid pulse one cycle after the 8th strobe, Error stays 0.
REQ-027 Stream 1 followed by eleven 0s (E) -> Letter=100 and exactly one LetterValid pulse.
REQ-028 Stream 11101011101 followed by 000 (C) with DotDashIn toggled randomly between strobes -> Letter=010 and one LetterValid pulse.
REQ-029 Stream 1,1,1,1,0 (4-unit mark) -> one Error pulse and no LetterValid; then 000 followed by 1010101000 (H) -> Letter=111 and LetterValid.
REQ-030 Stream 1,1,1,0,1 (partial B), then Resetn low for 2 cycles, then 1110101000 (D) -> outputs 0 during reset, then Letter=011 and a single LetterValid pulse.
REQ-031 Stream 1,0,1,0,1,0,1,0,1,000 (five dots) -> Error pulse, Letter unchanged from its previous value.
